// File: rtl/ext_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_ctrl
// Brief    : Word-addressed diary RAM with byte-lane writes, region decode,
//            programmable wait states and a hardware zero-fill engine.
// Revision : 1.0
// ============================================================================
module ext_mem_ctrl #(
  parameter int                              DATA_W      = 32,
  parameter int                              ADDR_W      = 32,
  parameter int                              DEPTH_LOG2  = 12,
  parameter int                              REGION_MSB  = 19,
  parameter int                              REGION_LSB  = 16,
  parameter logic [REGION_MSB-REGION_LSB:0]  REGION_ID   = 4'h1,
  parameter int                              WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  input  logic                clr_start,
  output logic                clr_busy
);

  localparam int         NB     = DATA_W / 8;
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DEPTH_LOG2-1:0] r_clr_cnt;
  logic [3:0]            r_wait_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_hit;
  logic [NB-1:0]         r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_in_hit;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_hit;
  logic [NB-1:0]         w_we;
  logic [DATA_W-1:0]     w_wdata;
  logic                  w_unused;

  // Bits between the word index and the region field are deliberately ignored.
  assign w_unused = ^addr;
  assign w_in_hit = (addr[REGION_MSB:REGION_LSB] == REGION_ID);

  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      CLEAR: begin
        if (r_clr_cnt == {DEPTH_LOG2{1'b1}}) w_next = IDLE;
      end
      IDLE: begin
        ready = !clr_start;
        if (clr_start) begin
          w_next = CLEAR;
        end else if (req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) w_next = RESP;
          else                  w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd1) w_next = RESP;
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = CLEAR;
      end
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // live inputs are used instead of the latched copies.
  assign w_commit = (w_next == RESP);
  assign w_idx    = (r_state == IDLE) ? addr[DEPTH_LOG2-1:0] : r_idx;
  assign w_hit    = (r_state == IDLE) ? w_in_hit : r_hit;
  assign w_we     = (r_state == IDLE) ? we : r_we;
  assign w_wdata  = (r_state == IDLE) ? wdata : r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_cnt  <= '0;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_hit      <= 1'b0;
      r_we       <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      if (r_state == CLEAR)                    r_clr_cnt <= r_clr_cnt + 1'b1;
      else if (r_state == IDLE && clr_start)   r_clr_cnt <= '0;
      if (w_accept) begin
        r_idx      <= addr[DEPTH_LOG2-1:0];
        r_hit      <= w_in_hit;
        r_we       <= we;
        r_wdata    <= wdata;
        r_wait_cnt <= C_WAIT;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= w_hit ? mem[w_idx] : '0;
        r_err   <= !w_hit;
      end
    end
  end

  // Storage has no reset; the clear engine owns its initial contents.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      mem[r_clr_cnt] <= '0;
    end else if (w_commit && w_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (w_we[i]) mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign rvalid   = (r_state == RESP);
  assign rdata    = r_rdata;
  assign err      = r_err;
  assign clr_busy = (r_state == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_mem_ctrl
// Brief    : Self-checking bench for ext_mem_ctrl with a word-array reference.
// Revision : 1.0
// ============================================================================
module tb_ext_mem_ctrl;

  localparam int W     = 1;
  localparam int DEPTH = 4096;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        req       = 1'b0;
  logic [3:0]  we        = 4'h0;
  logic [31:0] addr      = 32'h0;
  logic [31:0] wdata     = 32'h0;
  logic        clr_start = 1'b0;
  logic        ready, rvalid, err, clr_busy;
  logic [31:0] rdata;

  ext_mem_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .err       (err),
    .clr_start (clr_start),
    .clr_busy  (clr_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [DEPTH];
  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
  } resp_t;
  resp_t       q[$];
  logic [31:0] last_rdata = 32'h0;
  bit          mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every cycle: either the oldest pending response is due, or the bus is quiet.
  always @(negedge clk) begin
    if (mon_on) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("missed_resp", cyc, q[0].due);
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due == cyc) begin
        chk("resp_rvalid", {31'b0, rvalid}, 32'd1);
        chk("resp_err", {31'b0, err}, {31'b0, q[0].er});
        chk("resp_rdata", rdata, q[0].rd);
        last_rdata = rdata;
        void'(q.pop_front());
      end else begin
        chk("quiet_rvalid", {31'b0, rvalid}, 32'd0);
        chk("quiet_err", {31'b0, err}, 32'd0);
      end
    end
  end

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    int          n;
    resp_t       r;
    logic [11:0] idx;
    bit          hit;
    n = 0;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; wdata = d;
    #1;
    while (!ready && n < 20000) begin
      @(negedge clk); #1; n++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    idx   = a[11:0];
    hit   = (a[19:16] == 4'h1);
    r.due = cyc + 1 + W;
    r.er  = !hit;
    r.rd  = hit ? mm[idx] : 32'h0;
    if (hit) begin
      for (int i = 0; i < 4; i++) if (w[i]) mm[idx][8*i +: 8] = d[8*i +: 8];
    end
    q.push_back(r);
    @(posedge clk); #1;
    req = 1'b0; addr = $urandom; we = 4'($urandom); wdata = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (q.size() > 0) begin
      chk("resp_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    @(negedge clk); #1;
    while (clr_busy && n < 6000) begin
      @(negedge clk); #1; n++;
    end
    chk("clear_done", {31'b0, clr_busy}, 32'd0);
    zero_model();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    access(a, 4'h0, $urandom);
    wait_done();
    v = last_rdata;
  endtask

  function automatic logic [31:0] rand_addr(input bit hit, input logic [11:0] idx);
    logic [3:0] reg_f;
    reg_f = 4'($urandom_range(0, 15));
    if (reg_f == 4'h1) reg_f = 4'h2;
    return {12'h0, hit ? 4'h1 : reg_f, 4'($urandom), idx};
  endfunction

  initial begin
    int          n;
    logic [31:0] v;

    // Reset and initial clear
    #2 rst_n = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, clr_busy}, 32'd1);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (clr_busy && n < 5000) begin
      chk("clear_ready", {31'b0, ready}, 32'd0);
      n++;
      @(negedge clk); #1;
    end
    chk("clear_len", n, 32'd4096);
    zero_model();
    for (int i = 0; i < 64; i++) begin
      rd(rand_addr(1'b1, 12'($urandom)), v);
      chk("t1_read_zero", v, 32'h0);
    end

    // Byte-lane write with read-before-write
    access(32'h0001_0005, 4'hF, 32'h1122_3344);
    access(32'h0001_0005, 4'b0101, 32'hAABB_CCDD);
    wait_done();
    chk("t2_old_word", last_rdata, 32'h1122_3344);
    rd(32'h0001_0005, v);
    chk("t2_merged", v, 32'h11BB_33DD);

    // Region miss
    access(32'h0002_0005, 4'hF, 32'h5555_AAAA);
    wait_done();
    chk("t3_miss_rdata", last_rdata, 32'h0);
    rd(32'h0001_0005, v);
    chk("t3_unchanged", v, 32'h11BB_33DD);

    // Index wrap
    access(32'h0001_1003, 4'hF, 32'hDEAD_BEEF);
    rd(32'h0001_0003, v);
    chk("t4_wrap", v, 32'hDEAD_BEEF);

    // Random back-to-back traffic over a small word pool
    for (int i = 0; i < 300; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      access(rand_addr($urandom_range(0, 9) != 0, 12'($urandom_range(0, 15))), w, $urandom);
    end
    wait_done();

    // clr_start beats a simultaneous req
    @(negedge clk);
    req = 1'b1; clr_start = 1'b1; addr = 32'h0001_0005; we = 4'hF; wdata = 32'h0BAD_0BAD;
    #1;
    chk("t5_ready_low", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    chk("t5_clear_entered", {31'b0, clr_busy}, 32'd1);
    req = 1'b0; clr_start = 1'b0;
    wait_clear();
    rd(32'h0001_0005, v);
    chk("t5_cleared", v, 32'h0);

    // clr_start outside IDLE is ignored
    access(32'h0001_0007, 4'hF, 32'h1234_5678);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    wait_done();
    #1;
    chk("t5_no_clear", {31'b0, clr_busy}, 32'd0);
    rd(32'h0001_0007, v);
    chk("t5_write_kept", v, 32'h1234_5678);

    // Reset during the wait phase of a write
    access(32'h0001_0010, 4'hF, 32'hCAFE_F00D);
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("t6_no_rvalid", {31'b0, rvalid}, 32'd0);
    chk("t6_busy", {31'b0, clr_busy}, 32'd1);
    rst_n = 1'b1;
    wait_clear();
    rd(32'h0001_0010, v);
    chk("t6_word_zero", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
